// File: rtl/payload_scan_pkg.sv
// payload_scan_pkg
//   Shared types for the payload scan controller: FSM state encoding, the
//   drain length that covers the engine pipeline, and the result record
//   captured at the end of each packet.
//   The result record is sized from the DEF_* widths. The top-level
//   parameters default to these widths and must stay equal to them.
package payload_scan_pkg;

    localparam int DEF_NUM_ENGINES = 32;
    localparam int DEF_PKT_ID_W    = 16;
    localparam int DEF_LEN_W       = 11;

    // One cycle for the registered eng_en to reach the engines, plus one
    // cycle for the engine flops to update before the match is sampled.
    localparam int DRAIN_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_REPORT
    } state_t;

    typedef struct packed {
        logic [DEF_PKT_ID_W-1:0]    pkt_id;
        logic [DEF_NUM_ENGINES-1:0] match;
        logic                       any;
        logic [DEF_LEN_W-1:0]       len;
        logic                       err;
    } result_t;

endpackage

// File: rtl/payload_scan_stats.sv
// payload_scan_stats
//   Free-running 32-bit wrapping event counters for the scan controller.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     i_pkt_hs        result handshake this cycle
//     i_alert         result handshake with any match set
//     i_drop          non-sop beat dropped while idle
//     o_pkts          handshake count
//     o_alerts        alerting handshake count
//     o_drops         dropped beat count
module payload_scan_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_pkt_hs,
    input  logic        i_alert,
    input  logic        i_drop,
    output logic [31:0] o_pkts,
    output logic [31:0] o_alerts,
    output logic [31:0] o_drops
);

    logic [31:0] r_pkts;
    logic [31:0] r_alerts;
    logic [31:0] r_drops;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkts   <= '0;
            r_alerts <= '0;
            r_drops  <= '0;
        end else begin
            if (i_pkt_hs) r_pkts   <= r_pkts + 32'd1;
            if (i_alert)  r_alerts <= r_alerts + 32'd1;
            if (i_drop)   r_drops  <= r_drops + 32'd1;
        end
    end

    assign o_pkts   = r_pkts;
    assign o_alerts = r_alerts;
    assign o_drops  = r_drops;

endmodule

// File: rtl/payload_scan_ctrl.sv
// payload_scan_ctrl
//   Feeds packet payload bytes into a bank of regex engines and reports the
//   engine match vector once per packet.
//   Flow per packet: CLEAR (engine clear pulse) -> IDLE (wait for sop) ->
//   SCAN (one byte per cycle) -> DRAIN (engine pipeline settles) ->
//   REPORT (hold result until consumed).
//   Ports:
//     clk, rst                  clock, asynchronous active-high reset
//     s_valid/s_ready/s_data    payload byte stream
//     s_sop/s_eop/s_pkt_id      packet framing and tag (tag taken on sop)
//     eng_sod                   engine bank clear
//     eng_en/eng_byte           registered engine enable and byte
//     eng_match                 engine sticky match outputs
//     r_valid/r_ready           result handshake
//     r_pkt_id/r_match/r_any    captured tag, match vector and its OR
//     r_len/r_err               saturating byte count, truncation flag
//   Optional: define PAYLOAD_SCAN_STATS_EN to add the stat_pkts,
//   stat_alerts and stat_drops counter outputs.
module payload_scan_ctrl
    import payload_scan_pkg::*;
#(
    parameter int NUM_ENGINES = DEF_NUM_ENGINES,
    parameter int PKT_ID_W    = DEF_PKT_ID_W,
    parameter int LEN_W       = DEF_LEN_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [7:0]             s_data,
    input  logic                   s_sop,
    input  logic                   s_eop,
    input  logic [PKT_ID_W-1:0]    s_pkt_id,
    output logic                   eng_sod,
    output logic                   eng_en,
    output logic [7:0]             eng_byte,
    input  logic [NUM_ENGINES-1:0] eng_match,
`ifdef PAYLOAD_SCAN_STATS_EN
    output logic [31:0]            stat_pkts,
    output logic [31:0]            stat_alerts,
    output logic [31:0]            stat_drops,
`endif
    output logic                   r_valid,
    input  logic                   r_ready,
    output logic [PKT_ID_W-1:0]    r_pkt_id,
    output logic [NUM_ENGINES-1:0] r_match,
    output logic                   r_any,
    output logic [LEN_W-1:0]       r_len,
    output logic                   r_err
);

    state_t                r_state;
    state_t                w_next;
    logic [1:0]            r_drain_cnt;
    logic [PKT_ID_W-1:0]   r_id;
    logic [LEN_W-1:0]      r_len_cnt;
    logic                  r_err_flag;
    logic                  r_eng_en;
    logic [7:0]            r_eng_byte;
    result_t               r_res;
    logic                  w_take;
    logic                  w_trunc;
    logic                  w_drain_done;

    assign w_drain_done = (r_state == ST_DRAIN) &&
                          (r_drain_cnt == 2'(DRAIN_CYCLES - 1));

    always_comb begin
        w_next  = r_state;
        s_ready = 1'b0;
        eng_sod = 1'b0;
        w_take  = 1'b0;
        w_trunc = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                eng_sod = 1'b1;
                w_next  = ST_IDLE;
            end
            ST_IDLE: begin
                // Non-sop beats are accepted here and thrown away.
                s_ready = 1'b1;
                if (s_valid && s_sop) begin
                    w_take = 1'b1;
                    w_next = s_eop ? ST_DRAIN : ST_SCAN;
                end
            end
            ST_SCAN: begin
                // A new sop ends the current packet; the beat is held off
                // and picked up again once the bank has been cleared.
                if (s_valid && s_sop) begin
                    w_trunc = 1'b1;
                    w_next  = ST_DRAIN;
                end else begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        w_take = 1'b1;
                        if (s_eop) w_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_drain_done) w_next = ST_REPORT;
            end
            ST_REPORT: begin
                if (r_ready) w_next = ST_CLEAR;
            end
            default: w_next = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_CLEAR;
            r_drain_cnt <= '0;
            r_id        <= '0;
            r_len_cnt   <= '0;
            r_err_flag  <= 1'b0;
            r_eng_en    <= 1'b0;
            r_eng_byte  <= '0;
            r_res       <= '0;
        end else begin
            r_state     <= w_next;
            r_eng_en    <= w_take;
            if (w_take) r_eng_byte <= s_data;
            r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + 2'd1 : 2'd0;

            if (r_state == ST_CLEAR) begin
                r_len_cnt  <= '0;
                r_err_flag <= 1'b0;
            end else if (r_state == ST_IDLE && w_take) begin
                r_id      <= s_pkt_id;
                r_len_cnt <= LEN_W'(1);
            end else if (r_state == ST_SCAN && w_take && r_len_cnt != '1) begin
                r_len_cnt <= r_len_cnt + LEN_W'(1);
            end

            if (w_trunc) r_err_flag <= 1'b1;

            if (w_drain_done) begin
                r_res.pkt_id <= r_id;
                r_res.match  <= eng_match;
                r_res.any    <= |eng_match;
                r_res.len    <= r_len_cnt;
                r_res.err    <= r_err_flag;
            end
        end
    end

    assign eng_en   = r_eng_en;
    assign eng_byte = r_eng_byte;
    assign r_valid  = (r_state == ST_REPORT);
    assign r_pkt_id = r_res.pkt_id;
    assign r_match  = r_res.match;
    assign r_any    = r_res.any;
    assign r_len    = r_res.len;
    assign r_err    = r_res.err;

`ifdef PAYLOAD_SCAN_STATS_EN
    logic w_hs;
    logic w_drop;

    assign w_hs   = r_valid & r_ready;
    assign w_drop = (r_state == ST_IDLE) & s_valid & ~s_sop;

    payload_scan_stats u_stats (
        .clk      (clk),
        .rst      (rst),
        .i_pkt_hs (w_hs),
        .i_alert  (w_hs & r_res.any),
        .i_drop   (w_drop),
        .o_pkts   (stat_pkts),
        .o_alerts (stat_alerts),
        .o_drops  (stat_drops)
    );
`endif

endmodule

// File: doc/payload_scan_ctrl.md
Name: payload_scan_ctrl

Overview:
- Sequences packet payload bytes into a bank of NUM_ENGINES regex engines.
- Engines are one-hot character-driven state chains with sticky end states, cleared by sod and advanced by en.
- Per packet: clears the bank, streams each byte with en, waits for the engine pipeline to settle, then captures the match vector into a result record under a valid/ready handshake.
- Sits between the payload-extract stream and the alert/report logic.

Parameters:
- NUM_ENGINES, 32, number of engine match inputs.
- PKT_ID_W, 16, width of the packet tag carried through to the result.
- LEN_W, 11, width of the payload byte counter (saturating).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- s_valid  in  1  payload byte valid.
- s_ready  out  1  payload byte accepted when s_valid and s_ready are both 1.
- s_data  in  8  payload byte.
- s_sop  in  1  first byte of packet.
- s_eop  in  1  last byte of packet.
- s_pkt_id  in  PKT_ID_W  packet tag, sampled on the sop beat.
- eng_sod  out  1  engine bank clear (drives CLR of every engine flop).
- eng_en  out  1  engine bank clock enable.
- eng_byte  out  8  byte to the character decoder feeding in_* lines.
- eng_match  in  NUM_ENGINES  engine out bits.
- r_valid  out  1  result valid.
- r_ready  in  1  result consumed.
- r_pkt_id  out  PKT_ID_W  packet tag.
- r_match  out  NUM_ENGINES  captured match vector.
- r_any  out  1  OR of r_match.
- r_len  out  LEN_W  payload bytes accepted, saturating at 2^LEN_W-1.
- r_err  out  1  packet truncated by a sop arriving before its eop.

Behaviour:
- States:
  - CLEAR: eng_sod=1 for exactly 1 cycle, s_ready=0, then go to IDLE.
  - IDLE: s_ready=1. A beat with sop loads the id, sets len=1, drives the byte, and goes to SCAN, or to DRAIN if eop is also set. A beat without sop is dropped (drop_cnt increments) with eng_en=0.
  - SCAN: s_ready=1. Each accepted beat increments len; eop moves to DRAIN. A valid beat with sop=1 is not accepted (s_ready=0 that cycle); the FSM sets err and goes to DRAIN, and that beat is taken later in IDLE.
  - DRAIN: 2 cycles, s_ready=0, eng_en=0. Match is sampled at the end of the second cycle.
  - REPORT: r_valid=1, all r_* fields stable. r_valid & r_ready moves to CLEAR.
- eng_en and eng_byte are registered: eng_en=1 in the cycle after an accepted beat and 0 otherwise. eng_byte holds its last value when eng_en=0.
- Engine flops capture on the edge that ends the eng_en cycle, so the final byte's match is visible before DRAIN's second edge.
- Throughput: 1 byte/cycle in SCAN. Per-packet overhead is 2 (DRAIN) + ≥1 (REPORT) + 1 (CLEAR) + 1 (IDLE sop) cycles.
- len saturates, never wraps. err and len reset on leaving CLEAR.
- Reset:
  - Outputs: eng_sod=1, state=CLEAR, s_ready=0, eng_en=0, eng_byte=0, r_valid=0, r_match=0, r_any=0, r_len=0, r_err=0, r_pkt_id=0.
  - First cycle after deassertion is CLEAR, so the engines are cleared again.
  - Reset mid-packet discards the packet with no result.
- r_any is registered alongside r_match, not computed combinationally from live inputs.

Optional Feature:
- Macro PAYLOAD_SCAN_STATS_EN.
- Defined: adds outputs stat_pkts, stat_alerts, stat_drops, each 32 bits, wrapping, reset to 0.
  - stat_pkts increments on each result handshake.
  - stat_alerts increments on a handshake with r_any=1.
  - stat_drops increments per dropped non-sop beat in IDLE.
- Undefined: those ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package payload_scan_pkg holds:
  - state enum (CLEAR, IDLE, SCAN, DRAIN, REPORT);
  - DRAIN_CYCLES=2;
  - the result record typedef (pkt_id, match, any, len, err).
- Optional sub-module payload_scan_stats holds the three counters, instantiated only under PAYLOAD_SCAN_STATS_EN.

Test Plan:
- Reset release → eng_sod=1 for 1 cycle, s_ready rises on the 2nd cycle; r_valid=0 throughout.
- 5-byte packet id=0x00A1, engine model raises bit 3 on byte 4 → r_match=0x00000008, r_any=1, r_len=5, r_err=0. Result is held stable with r_ready=0 for 10 cycles, then eng_sod pulses once.
- Single-byte packet (sop&eop) → DRAIN 2 cycles, r_len=1. Back-to-back packets then sustain 1 byte/cycle in SCAN.
- Packet A with 3 bytes, no eop, then sop of B → A reported with r_err=1, r_len=3. B's first byte is accepted only after CLEAR, and B reports r_err=0.
- 2^LEN_W+5 byte packet → r_len=2047 (saturated). 3 beats without sop while in IDLE → no eng_en pulses, stat_drops=3 (stats build).
